// File: rtl/tx_serializer.sv
// -----------------------------------------------------------------------------
// tx_serializer
//
// Frames a WIDTH-bit word onto a single serial line:
//   start(0), WIDTH data bits LSB first, optional even-parity bit, stop(1).
// Each line bit is held for BIT_CYCLES clocks. The frame finishes with a
// one-cycle DONE state that raises TxDone. The block then returns to IDLE.
//
// A separate holding register captures DataIn on every SampleData strobe. A
// frame starts from DataIn when SampleData arrives on the same edge as the
// accepted TxData. Otherwise it starts from the holding register. Once a
// frame starts, only the shift register feeds the line, so later strobes do
// not change the frame in flight.
//
// Parameters
//   WIDTH      data bits per frame
//   BIT_CYCLES clocks per serial bit (1..255)
//   PARITY_EN  1 = insert an even-parity bit after the data, 0 = omit it
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous, active-high reset
//   DataIn     word to transmit
//   SampleData load strobe for the holding register
//   TxData     transmit request; honoured only in IDLE
//   SOut       registered serial line; idles high
//   TxBusy     high while start/data/parity/stop are on the line
//   TxDone     one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
module tx_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             SampleData,
    input  logic             TxData,
    output logic             SOut,
    output logic             TxBusy,
    output logic             TxDone
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q,  hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cyc_q,   cyc_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic             par_q,   par_d;
    logic             sout_q,  sout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             bit_end;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        par_d   = par_q;

        // The holding register follows SampleData in every state. Its next
        // value is also the load value when SampleData and TxData coincide.
        hold_d  = SampleData ? DataIn : hold_q;

        bit_end = (cyc_q == CYC_LAST);

        case (state_q)
            S_IDLE: begin
                if (TxData) begin
                    shift_d = hold_d;
                    // Parity is fixed at load, because the shift register
                    // is consumed as the data bits go out.
                    par_d   = ^hold_d;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The outputs are decoded from the next state, so the registered
        // outputs change on the same edge that the state changes.
        case (state_d)
            S_START:  sout_d = 1'b0;
            S_DATA:   sout_d = shift_d[0];
            S_PARITY: sout_d = par_d;
            default:  sout_d = 1'b1;
        endcase

        busy_d = (state_d == S_START) || (state_d == S_DATA) ||
                 (state_d == S_PARITY) || (state_d == S_STOP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            shift_q <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SOut   = sout_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_tx_serializer
//
// Uses two instances of tx_serializer:
//   dut_a  default parameters (WIDTH 8, BIT_CYCLES 4, parity enabled)
//   dut_b  BIT_CYCLES 1 with parity disabled
//
// Each transmit request pushes the expected per-cycle {SOut, TxBusy, TxDone}
// sequence of its frame onto a queue. Each scenario task pops one entry per
// clock on the falling edge and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic sout;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = '{sout: 1'b1, busy: 1'b0, done: 1'b0};

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic       rst_a, samp_a, txd_a, sout_a, busy_a, done_a;
    logic [7:0] din_a;
    logic       rst_b, samp_b, txd_b, sout_b, busy_b, done_b;
    logic [7:0] din_b;

    tx_serializer dut_a (
        .Clk(clk), .Reset(rst_a), .DataIn(din_a), .SampleData(samp_a),
        .TxData(txd_a), .SOut(sout_a), .TxBusy(busy_a), .TxDone(done_a)
    );

    tx_serializer #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(0)) dut_b (
        .Clk(clk), .Reset(rst_b), .DataIn(din_b), .SampleData(samp_b),
        .TxData(txd_b), .SOut(sout_b), .TxBusy(busy_b), .TxDone(done_b)
    );

    // Expected line for one frame, followed by the single IDLE cycle that
    // comes after DONE.
    function automatic void push_frame(input bit to_b, input logic [7:0] w,
                                       input int bc, input bit pen);
        exp_t seq[$];
        logic p;
        p = 1'b0;
        for (int k = 0; k < 8; k++) p = p ^ w[k];
        for (int i = 0; i < bc; i++) seq.push_back('{1'b0, 1'b1, 1'b0});
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < bc; i++) seq.push_back('{w[b], 1'b1, 1'b0});
        if (pen)
            for (int i = 0; i < bc; i++) seq.push_back('{p, 1'b1, 1'b0});
        for (int i = 0; i < bc; i++) seq.push_back('{1'b1, 1'b1, 1'b0});
        seq.push_back('{1'b1, 1'b0, 1'b1});
        seq.push_back(IDLE_E);
        foreach (seq[k]) begin
            if (to_b) exp_b.push_back(seq[k]);
            else      exp_a.push_back(seq[k]);
        end
    endfunction

    function automatic void push_idle(input bit to_b, input int n);
        for (int i = 0; i < n; i++) begin
            if (to_b) exp_b.push_back(IDLE_E);
            else      exp_a.push_back(IDLE_E);
        end
    endfunction

    task automatic test_reset;
        exp_t e;
        int   c;
        // Reset is held together with load and transmit requests. Reset must
        // win, so no frame may start and the holding register must stay 0.
        rst_a = 1; samp_a = 1; txd_a = 1; din_a = 8'hFF;
        rst_b = 1; samp_b = 1; txd_b = 1; din_b = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({sout_a, busy_a, done_a} !== 3'b100)
            $display("FAIL reset_a: got %b want 100", {sout_a, busy_a, done_a});
        else n_pass++;
        n_chk++;
        if ({sout_b, busy_b, done_b} !== 3'b100)
            $display("FAIL reset_b: got %b want 100", {sout_b, busy_b, done_b});
        else n_pass++;
        rst_a = 0; samp_a = 0; txd_a = 0; din_a = 8'h00;
        rst_b = 0; samp_b = 0; txd_b = 0; din_b = 8'h00;
        push_idle(0, 2);
        c = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL post_reset_idle c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
        // TxData alone must send the cleared holding register (0x00).
        txd_a = 1;
        push_frame(0, 8'h00, 4, 1);
        c = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            txd_a = 0;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL hold_cleared c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
    endtask

    task automatic test_same_edge;
        exp_t e;
        int   c;
        din_a = 8'h3C; samp_a = 1; txd_a = 1;
        push_frame(0, 8'h3C, 4, 1);
        c = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            samp_a = 0; txd_a = 0;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL same_edge c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
    endtask

    task automatic test_defaults;
        exp_t e;
        int   c, done_at;
        // Load first, then transmit from the holding register.
        din_a = 8'hA5; samp_a = 1;
        @(negedge clk);
        samp_a = 0; din_a = 8'h00; txd_a = 1;
        push_frame(0, 8'hA5, 4, 1);
        c = 0; done_at = -1;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            txd_a = 0;
            if (done_a === 1'b1 && done_at < 0) done_at = c;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL defaults_A5 c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
        n_chk++;
        if (done_at !== 45)
            $display("FAIL done_latency: got %0d want 45", done_at);
        else n_pass++;
    endtask

    task automatic test_midframe;
        exp_t e;
        int   c, dones;
        // The holding register still contains A5 from the previous test.
        txd_a = 1;
        push_frame(0, 8'hA5, 4, 1);
        c = 0; dones = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            txd_a = 0; samp_a = 0;
            if (done_a === 1'b1) dones++;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL midframe c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
            if (c == 10) begin
                txd_a = 1; samp_a = 1; din_a = 8'h01;
            end
        end
        n_chk++;
        if (dones !== 1) $display("FAIL midframe_dones: got %0d want 1", dones);
        else n_pass++;
        txd_a = 1;
        push_frame(0, 8'h01, 4, 1);
        c = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            txd_a = 0;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL held_01 c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe;
        exp_t e;
        int   c, dones;
        din_a = 8'h96; samp_a = 1; txd_a = 1;
        push_frame(0, 8'h96, 4, 1);
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            samp_a = 0; txd_a = 0;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL pre_abort c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
        // Cycle 10 is in the middle of data bit 1.
        exp_a.delete();
        rst_a = 1;
        push_idle(0, 6);
        c = 0; dones = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            rst_a = 0;
            if (done_a === 1'b1) dones++;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL abort_idle c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
        n_chk++;
        if (dones !== 0) $display("FAIL abort_dones: got %0d want 0", dones);
        else n_pass++;
        din_a = 8'h5A; samp_a = 1; txd_a = 1;
        push_frame(0, 8'h5A, 4, 1);
        c = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            samp_a = 0; txd_a = 0;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL clean_after_abort c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   c, dones;
        din_a = 8'hC3; samp_a = 1; txd_a = 1;
        for (int f = 0; f < 3; f++) push_frame(0, 8'hC3, 4, 1);
        c = 0; dones = 0;
        while (exp_a.size() > 0) begin
            @(negedge clk); c++;
            samp_a = 0;
            if (done_a === 1'b1) dones++;
            e = exp_a.pop_front();
            n_chk++;
            if ({sout_a, busy_a, done_a} !== e)
                $display("FAIL back_to_back c%0d: got %b want %b", c, {sout_a, busy_a, done_a}, e);
            else n_pass++;
        end
        // Drop TxData in the last IDLE cycle so that no fourth frame starts.
        txd_a = 0;
        n_chk++;
        if (dones !== 3) $display("FAIL b2b_dones: got %0d want 3", dones);
        else n_pass++;
    endtask

    task automatic test_no_parity;
        exp_t e;
        int   c, busy_cnt, done_at;
        din_b = 8'hFF; samp_b = 1; txd_b = 1;
        push_frame(1, 8'hFF, 1, 0);
        c = 0; busy_cnt = 0; done_at = -1;
        while (exp_b.size() > 0) begin
            @(negedge clk); c++;
            samp_b = 0; txd_b = 0;
            if (busy_b === 1'b1) busy_cnt++;
            if (done_b === 1'b1 && done_at < 0) done_at = c;
            e = exp_b.pop_front();
            n_chk++;
            if ({sout_b, busy_b, done_b} !== e)
                $display("FAIL no_parity_FF c%0d: got %b want %b", c, {sout_b, busy_b, done_b}, e);
            else n_pass++;
        end
        n_chk++;
        if (busy_cnt !== 10) $display("FAIL np_busy_cycles: got %0d want 10", busy_cnt);
        else n_pass++;
        n_chk++;
        if (done_at !== 11) $display("FAIL np_done_cycle: got %0d want 11", done_at);
        else n_pass++;
    endtask

    initial begin
        rst_a = 1; samp_a = 0; txd_a = 0; din_a = 8'h00;
        rst_b = 1; samp_b = 0; txd_b = 0; din_b = 8'h00;
        test_reset();
        test_same_edge();
        test_defaults();
        test_midframe();
        test_reset_midframe();
        test_back_to_back();
        test_no_parity();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
